pulse_timer: RTL and testbench

PULSE_TIMER -- requirements
Module: pulse_timer

---
 rtl/pop_timing_pkg.sv | 14 +
 rtl/dn_counter.sv | 29 ++
 rtl/pulse_timer.sv | 166 ++++++++++++++++
 tb/tb_pulse_timer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pop_timing_pkg.sv
// Shared timing definitions for the pulse-train timer: the FSM state
// encoding and the default field width.
package pop_timing_pkg;

    localparam int unsigned PT_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        PT_IDLE  = 2'd0,
        PT_DELAY = 2'd1,
        PT_HIGH  = 2'd2,
        PT_LOW   = 2'd3
    } pt_state_t;

endpackage

// File: rtl/dn_counter.sv
// Loadable down-counter with a zero flag; times every phase of the train.
module dn_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Load wins over decrement; the count never wraps below zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_timer.sv
// Programmable pulse-train generator: optional start delay, then n_pulses
// pulses of t_high cycles separated by t_low cycles. Fields are latched on
// start acceptance. Optional feature macro: PULSE_TIMER_ABORT_EN adds the
// abort input, which stops a running train early.
module pulse_timer
    import pop_timing_pkg::*;
#(
    parameter int unsigned WIDTH = PT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef PULSE_TIMER_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIDTH-1:0] delay,
    input  logic [WIDTH-1:0] t_high,
    input  logic [WIDTH-1:0] t_low,
    input  logic [WIDTH-1:0] n_pulses,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] pulse_idx
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    pt_state_t        state;
    logic [WIDTH-1:0] delay_sh;
    logic [WIDTH-1:0] t_high_sh;
    logic [WIDTH-1:0] t_low_sh;
    logic [WIDTH-1:0] n_sh;

    logic             cnt_load;
    logic             cnt_en;
    logic [WIDTH-1:0] cnt_value;
    logic [WIDTH-1:0] cnt;
    logic             cnt_zero;

    logic [WIDTH-1:0] idx_next;
    logic             last_pulse;

    // Counter preload for a phase of length max(len,1): the phase ends when
    // the count reaches zero, so a zero length still gives one cycle.
    function automatic logic [WIDTH-1:0] last_of(input logic [WIDTH-1:0] len);
        return (len == '0) ? '0 : len - ONE;
    endfunction

    assign idx_next   = pulse_idx + ONE;
    assign last_pulse = (idx_next == n_sh);

    dn_counter #(.WIDTH(WIDTH)) u_phase_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .enable     (cnt_en),
        .load_value (cnt_value),
        .count      (cnt),
        .zero       (cnt_zero)
    );

    // Phase counter control: preload on entry to each phase, count down otherwise.
    always_comb begin
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        cnt_value = '0;
        unique case (state)
            PT_IDLE: begin
                // Shadow registers are not yet loaded here, so use the inputs.
                if (start && (n_pulses != '0)) begin
                    cnt_load  = 1'b1;
                    cnt_value = (delay != '0) ? delay - ONE : last_of(t_high);
                end
            end
            PT_DELAY, PT_LOW: begin
                if (cnt_zero) begin
                    cnt_load  = 1'b1;
                    cnt_value = last_of(t_high_sh);
                end else begin
                    cnt_en = 1'b1;
                end
            end
            PT_HIGH: begin
                if (cnt_zero) begin
                    cnt_load  = !last_pulse;
                    cnt_value = last_of(t_low_sh);
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Train sequencing with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= PT_IDLE;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pulse_idx <= '0;
            delay_sh  <= '0;
            t_high_sh <= '0;
            t_low_sh  <= '0;
            n_sh      <= '0;
        end
`ifdef PULSE_TIMER_ABORT_EN
        else if (abort && (state != PT_IDLE)) begin
            state     <= PT_IDLE;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
        end
`endif
        else begin
            done <= 1'b0;
            unique case (state)
                PT_IDLE: begin
                    if (start) begin
                        delay_sh  <= delay;
                        t_high_sh <= t_high;
                        t_low_sh  <= t_low;
                        n_sh      <= n_pulses;
                        pulse_idx <= '0;
                        if (n_pulses == '0) begin
                            done <= 1'b1;
                        end else if (delay != '0) begin
                            state <= PT_DELAY;
                            busy  <= 1'b1;
                        end else begin
                            state     <= PT_HIGH;
                            busy      <= 1'b1;
                            pulse_out <= 1'b1;
                        end
                    end
                end
                PT_DELAY, PT_LOW: begin
                    if (cnt_zero) begin
                        state     <= PT_HIGH;
                        pulse_out <= 1'b1;
                    end
                end
                PT_HIGH: begin
                    if (cnt_zero) begin
                        pulse_idx <= idx_next;
                        pulse_out <= 1'b0;
                        if (last_pulse) begin
                            state <= PT_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= PT_LOW;
                        end
                    end
                end
                default: begin
                    state     <= PT_IDLE;
                    pulse_out <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_timer.sv
// Self-checking bench for pulse_timer: directed and randomized pulse trains
// compared cycle by cycle against a waveform model built from the train
// parameters with plain arithmetic.
module tb_pulse_timer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
`ifdef PULSE_TIMER_ABORT_EN
    logic         abort = 1'b0;
`endif
    logic [W-1:0] delay = '0;
    logic [W-1:0] t_high = '0;
    logic [W-1:0] t_low = '0;
    logic [W-1:0] n_pulses = '0;
    logic         pulse_out;
    logic         busy;
    logic         done;
    logic [W-1:0] pulse_idx;

    int n_asserts = 0;
    int n_fails   = 0;

    // Parameters of the train currently being modelled
    int m_d, m_h, m_l, m_n;

    always #5 clk = ~clk;

    pulse_timer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
`ifdef PULSE_TIMER_ABORT_EN
        .abort     (abort),
`endif
        .delay     (delay),
        .t_high    (t_high),
        .t_low     (t_low),
        .n_pulses  (n_pulses),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done),
        .pulse_idx (pulse_idx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waveform model: cycle k counts from 1 = first cycle after acceptance.
    function automatic int hi_len();
        return (m_h == 0) ? 1 : m_h;
    endfunction

    function automatic int lo_len();
        return (m_l == 0) ? 1 : m_l;
    endfunction

    function automatic int total_len();
        return (m_n == 0) ? 0 : m_d + m_n * hi_len() + (m_n - 1) * lo_len();
    endfunction

    function automatic int exp_pulse(input int k);
        int t;
        t = k - 1 - m_d;
        if (k > total_len() || t < 0) return 0;
        return ((t % (hi_len() + lo_len())) < hi_len()) ? 1 : 0;
    endfunction

    function automatic int exp_idx(input int k);
        int t;
        int p;
        t = k - 1 - m_d;
        p = hi_len() + lo_len();
        if (k > total_len()) return m_n;
        if (t < 0) return 0;
        return t / p + (((t % p) >= hi_len()) ? 1 : 0);
    endfunction

    task automatic check_cycle(input string tag, input int k);
        chk({tag, ".pulse_out"}, 32'(pulse_out), 32'(exp_pulse(k)));
        chk({tag, ".busy"},      32'(busy), 32'((k >= 1 && k <= total_len()) ? 1 : 0));
        chk({tag, ".done"},      32'(done), 32'((k == total_len() + 1) ? 1 : 0));
        chk({tag, ".pulse_idx"}, 32'(pulse_idx), 32'(exp_idx(k)));
    endtask

    task automatic check_quiet(input string tag, input int idx, input int dn);
        chk({tag, ".pulse_out"}, 32'(pulse_out), 32'(0));
        chk({tag, ".busy"},      32'(busy), 32'(0));
        chk({tag, ".done"},      32'(done), 32'(dn));
        chk({tag, ".pulse_idx"}, 32'(pulse_idx), 32'(idx));
    endtask

    // Present a start request with the given fields; returns in cycle k=1.
    task automatic launch(input int d, input int h, input int l, input int n);
        m_d = d; m_h = h; m_l = l; m_n = n;
        start    = 1'b1;
        delay    = W'(d);
        t_high   = W'(h);
        t_low    = W'(l);
        n_pulses = W'(n);
        tick();
    endtask

    // Full train: junk scrambles inputs mid-train, hold keeps start high,
    // gap adds idle cycles after done.
    task automatic run_train(input string tag, input int d, input int h, input int l,
                             input int n, input bit junk, input bit hold, input int gap);
        int last;
        launch(d, h, l, n);
        last = total_len() + 1 + gap;
        for (int k = 1; k <= last; k++) begin
            check_cycle(tag, k);
            if (k < last) begin
                if (k <= total_len()) begin
                    start = hold ? 1'b1 : (junk ? 1'($urandom) : 1'b0);
                    if (junk) begin
                        delay    = W'($urandom);
                        t_high   = W'($urandom);
                        t_low    = W'($urandom);
                        n_pulses = W'($urandom);
                    end
                end else begin
                    start = 1'b0;
                end
                tick();
            end
        end
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        tick(); tick(); tick();
        check_quiet("reset_hold", 0, 0);
        reset = 1'b1;
        tick();
        check_quiet("reset_release", 0, 0);

        run_train("basic_3_2_4_x3", 3, 2, 4, 3, 1'b0, 1'b0, 2);
        run_train("zero_fields_x2", 0, 0, 0, 2, 1'b0, 1'b0, 1);
        run_train("n_zero", 5, 3, 2, 0, 1'b0, 1'b0, 2);
        run_train("junk_mid_train", 2, 3, 2, 3, 1'b1, 1'b0, 1);

        // Held start re-triggers straight after done
        run_train("hold_first", 1, 1, 2, 2, 1'b0, 1'b1, 0);
        run_train("hold_second", 0, 2, 1, 1, 1'b0, 1'b0, 1);

        // Reset during the second HIGH pulse
        launch(1, 3, 2, 4);
        for (int k = 1; k <= 8; k++) begin
            check_cycle("pre_reset", k);
            start = 1'b0;
            if (k < 8) tick();
        end
        reset = 1'b0;
        tick();
        check_quiet("mid_reset", 0, 0);
        reset = 1'b1;
        tick();
        check_quiet("post_reset_release", 0, 0);
        run_train("after_reset", 2, 1, 1, 2, 1'b0, 1'b0, 1);

`ifdef PULSE_TIMER_ABORT_EN
        // Abort in LOW after the first of five pulses
        launch(2, 2, 3, 5);
        for (int k = 1; k <= 5; k++) begin
            check_cycle("pre_abort", k);
            start = 1'b0;
            if (k < 5) tick();
        end
        abort = 1'b1;
        tick();
        check_quiet("abort_next", 1, 1);
        abort = 1'b0;
        tick();
        check_quiet("abort_after", 1, 0);
        abort = 1'b1;
        tick();
        check_quiet("abort_in_idle", 1, 0);
        abort = 1'b0;
        tick();
`endif

        // Every field at its maximum value
        run_train("all_max", 15, 15, 15, 15, 1'b1, 1'b0, 1);

        // Randomized trains
        for (int i = 0; i < 24; i++) begin
            run_train($sformatf("rand%0d", i),
                      int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                      1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end
        start = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
